// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I datapath and pipeline_hazard_ctrl.
//   master : datapath side; drives register ids, write enables and events,
//            receives forwarding selects, stalls, flushes, Busy and StallCnt.
//   slave  : hazard controller side (mirror of master).
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       Rs1D, Rs2D;
   logic [4:0]       Rs1E, Rs2E, RdE;
   logic [4:0]       RdM, RdW;
   logic             ResultSrcE0;
   logic             RegWriteM, RegWriteW;
   logic             PCSrcE;
   logic             MultiCycE;
   logic             ImemReady;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE;
   logic             FlushD, FlushE, FlushM;
   logic             Busy;
   logic [CNT_W-1:0] StallCnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MultiCycE, ImemReady,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE,
             FlushD, FlushE, FlushM, Busy, StallCnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MultiCycE, ImemReady,
      output ForwardAE, ForwardBE, StallF, StallD, StallE,
             FlushD, FlushE, FlushM, Busy, StallCnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Produces operand forwarding selects, stall/flush controls for the PC,
// IF/ID, ID/EX and EX/MEM registers, sequences multi-cycle EX ops (mul/div)
// and counts fetch-stall cycles in a saturating counter.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   hz     : hazard bundle (slave side), see pipeline_hazard_ctrl_if
//
// state | meaning
// IDLE  | no multi-cycle op in flight; a MultiCycE op in EX starts one
// BUSY  | op in flight; cnt counts remaining stall cycles, cnt==0 is release
module pipeline_hazard_ctrl #(
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int CW = $clog2(MC_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       mc_stall, lw_stall;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_f, stall_d, stall_e;
   logic       flush_d, flush_e, flush_m;

   // M stage wins over W because it holds the younger result.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       wr_m,
                                          input logic [4:0] rd_w,
                                          input logic       wr_w);
      if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
      else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
      else                                         return 2'b00;
   endfunction

   assign mc_stall = (state_q == IDLE && hz.MultiCycE) ||
                     (state_q == BUSY && cnt_q != '0);
   assign lw_stall = hz.ResultSrcE0 && hz.RdE != 5'd0 &&
                     (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);

   always_comb begin
      fwd_a   = 2'b00;
      fwd_b   = 2'b00;
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      if (reset) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         flush_m = 1'b1;
      end else begin
         fwd_a = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
         fwd_b = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
         if (mc_stall) begin
            // EX holds the op, a bubble goes to MEM; the branch waits its turn
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
         end else if (hz.PCSrcE) begin
            // PC must take the target even if the fetch is not ready
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end else if (!hz.ImemReady) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         IDLE: begin
            if (hz.MultiCycE) begin
               state_d = BUSY;
               cnt_d   = CW'(MC_CYCLES - 2);
            end
         end
         BUSY: begin
            // cnt==0 is the release edge: ID/EX loads the next instruction,
            // so MultiCycE seen now belongs to the old op and must not retrigger
            if (cnt_q != '0) cnt_d   = cnt_q - CW'(1);
            else             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (stall_f && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.ForwardAE = fwd_a;
   assign hz.ForwardBE = fwd_b;
   assign hz.StallF    = stall_f;
   assign hz.StallD    = stall_d;
   assign hz.StallE    = stall_e;
   assign hz.FlushD    = flush_d;
   assign hz.FlushE    = flush_e;
   assign hz.FlushM    = flush_m;
   assign hz.Busy      = !reset && state_q == BUSY;
   assign hz.StallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int MC    = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

   pipeline_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hif)
   );

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       ld, rwm, rww, pcsrc, mc, imem;
   } in_t;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic       sf, sd, se, fd, fe, fm, busy;
   } out_t;

   typedef struct {
      string nm;
      in_t   i;
      out_t  o;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // reference state: remaining EX cycles of the op in flight, and stall count
   int m_left = 0;
   int m_cnt  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t v);
      if (rs == 0) return 2'b00;
      if (v.rwm && v.rdm == rs) return 2'b10;
      if (v.rww && v.rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic out_t ref_out(input in_t v);
      out_t o = '0;
      bit mc, lw;
      if (v.rst) begin
         o.fd = 1; o.fe = 1; o.fm = 1;
         return o;
      end
      o.fa   = ref_fwd(v.rs1e, v);
      o.fb   = ref_fwd(v.rs2e, v);
      o.busy = (m_left > 0);
      // op occupies EX for MC cycles; every cycle but the last one stalls
      mc = (m_left == 0 && v.mc) || (m_left > 1);
      lw = v.ld && v.rde != 0 && (v.rs1d == v.rde || v.rs2d == v.rde);
      if (mc)             begin o.sf = 1; o.sd = 1; o.se = 1; o.fm = 1; end
      else if (v.pcsrc)   begin o.fd = 1; o.fe = 1; end
      else if (lw)        begin o.sf = 1; o.sd = 1; o.fe = 1; end
      else if (!v.imem)   begin o.sf = 1; o.fd = 1; end
      return o;
   endfunction

   task automatic ref_step(input in_t v);
      out_t o;
      o = ref_out(v);
      if (v.rst) begin
         m_left = 0;
         m_cnt  = 0;
      end else begin
         if (o.sf && m_cnt < CMAX) m_cnt++;
         if (m_left > 0) m_left--;
         else if (v.mc)  m_left = MC - 1;
      end
   endtask

   function automatic in_t quiet();
      in_t v = '0;
      v.imem = 1'b1;
      return v;
   endfunction

   function automatic out_t outs(input logic [1:0] fa, input logic [1:0] fb,
                                 input logic sf, input logic sd, input logic se,
                                 input logic fd, input logic fe, input logic fm,
                                 input logic busy);
      out_t o;
      o.fa = fa; o.fb = fb; o.sf = sf; o.sd = sd; o.se = se;
      o.fd = fd; o.fe = fe; o.fm = fm; o.busy = busy;
      return o;
   endfunction

   task automatic drive(input in_t v);
      reset           = v.rst;
      hif.Rs1D        = v.rs1d;
      hif.Rs2D        = v.rs2d;
      hif.Rs1E        = v.rs1e;
      hif.Rs2E        = v.rs2e;
      hif.RdE         = v.rde;
      hif.RdM         = v.rdm;
      hif.RdW         = v.rdw;
      hif.ResultSrcE0 = v.ld;
      hif.RegWriteM   = v.rwm;
      hif.RegWriteW   = v.rww;
      hif.PCSrcE      = v.pcsrc;
      hif.MultiCycE   = v.mc;
      hif.ImemReady   = v.imem;
   endtask

   // One cycle: drive at negedge, sample 1ns later, then take the posedge.
   task automatic apply(input string nm, input in_t v, input out_t exp_in,
                        input bit use_ref);
      out_t act, exp;
      @(negedge clk);
      drive(v);
      #1;
      exp = use_ref ? ref_out(v) : exp_in;
      act = {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
             hif.FlushD, hif.FlushE, hif.FlushM, hif.Busy};
      chk({nm, ".outs"}, int'(act), int'(exp));
      chk({nm, ".cnt"}, int'(hif.StallCnt), m_cnt);
      @(posedge clk);
      ref_step(v);
   endtask

   task automatic chk_cnt(input string nm, input int exp);
      #2;
      chk(nm, int'(hif.StallCnt), exp);
   endtask

   task automatic do_reset();
      in_t v = quiet();
      v.rst = 1'b1;
      apply("reset", v, outs(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0), 1'b0);
   endtask

   vec_t tbl[$];

   initial begin
      in_t  v;
      out_t z;
      z = '0;
      drive(quiet());
      reset = 1'b1;

      // ---- table of single-cycle vectors, each applied from IDLE ----
      v = quiet(); v.rs1e = 5; v.rdm = 5; v.rwm = 1; v.rdw = 5; v.rww = 1;
      tbl.push_back('{"fwdA_M", v, outs(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0)});
      v.rwm = 0;
      tbl.push_back('{"fwdA_W", v, outs(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)});
      v.rs1e = 0; v.rdm = 0; v.rwm = 1;
      tbl.push_back('{"fwdA_x0", v, z});
      v = quiet(); v.rs2e = 9; v.rdm = 9; v.rwm = 1; v.rdw = 9; v.rww = 1;
      tbl.push_back('{"fwdB_M", v, outs(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0)});
      v.rdm = 3;
      tbl.push_back('{"fwdB_W", v, outs(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0)});
      v = quiet(); v.rs1e = 0; v.rdw = 0; v.rww = 1;
      tbl.push_back('{"fwdW_x0", v, z});
      v = quiet(); v.ld = 1; v.rde = 7; v.rs2d = 7;
      tbl.push_back('{"loaduse", v, outs(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0)});
      v = quiet(); v.ld = 1; v.rde = 7; v.rs1d = 7; v.imem = 0;
      tbl.push_back('{"lw_imem", v, outs(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0)});
      v = quiet(); v.ld = 1; v.rde = 0; v.rs1d = 0;
      tbl.push_back('{"lw_x0", v, z});
      v = quiet(); v.pcsrc = 1; v.ld = 1; v.rde = 7; v.rs1d = 7; v.imem = 0;
      tbl.push_back('{"br_lw_imem", v, outs(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0)});
      v = quiet(); v.imem = 0;
      tbl.push_back('{"imem_wait", v, outs(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0)});
      v = quiet(); v.rst = 1; v.rs1e = 5; v.rdm = 5; v.rwm = 1; v.mc = 1;
      tbl.push_back('{"rst_outs", v, outs(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0)});

      do_reset();
      chk_cnt("cnt_after_reset", 0);
      foreach (tbl[k]) apply(tbl[k].nm, tbl[k].i, tbl[k].o, 1'b0);

      // ---- load-use: single stall cycle, counter 0 -> 1 ----
      do_reset();
      v = quiet(); v.ld = 1; v.rde = 7; v.rs2d = 7;
      apply("lu_c0", v, outs(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0), 1'b0);
      chk_cnt("lu_cnt", 1);
      apply("lu_c1", quiet(), z, 1'b0);

      // ---- branch beats load-use and fetch wait, counter unchanged ----
      v = quiet(); v.pcsrc = 1; v.ld = 1; v.rde = 7; v.rs2d = 7; v.imem = 0;
      apply("br_prio", v, outs(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0), 1'b0);
      chk_cnt("br_cnt", 1);

      // ---- multi-cycle op, MC=4, MultiCycE held through EX occupancy ----
      do_reset();
      v = quiet(); v.mc = 1; v.imem = 0; v.pcsrc = 1;
      apply("mc_c0", v, outs(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0), 1'b0);
      apply("mc_c1", v, outs(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1), 1'b0);
      apply("mc_c2", v, outs(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1), 1'b0);
      v.imem = 1; v.pcsrc = 0;
      apply("mc_c3", v, outs(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1), 1'b0);
      v.mc = 0;
      apply("mc_c4", v, z, 1'b0);
      chk_cnt("mc_cnt", 3);

      // ---- back-to-back multi-cycle ops ----
      v = quiet(); v.mc = 1;
      for (int c = 0; c < 2 * MC; c++) apply("mc_b2b", v, z, 1'b1);
      chk_cnt("b2b_cnt", 3 + 2 * (MC - 1));

      // ---- reset mid-op aborts it ----
      do_reset();
      v = quiet(); v.mc = 1;
      apply("rm_c0", v, outs(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0), 1'b0);
      v.rst = 1;
      apply("rm_c1", v, outs(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0), 1'b0);
      apply("rm_c2", quiet(), z, 1'b0);
      apply("rm_c3", quiet(), z, 1'b0);
      chk_cnt("rm_cnt", 0);

      // ---- fetch-stall counter saturation ----
      do_reset();
      v = quiet(); v.imem = 0;
      for (int c = 0; c < 20; c++)
         apply("sat", v, outs(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0), 1'b0);
      chk_cnt("sat_cnt", CMAX);
      apply("sat_hold", quiet(), z, 1'b0);
      chk_cnt("sat_hold_cnt", CMAX);

      // ---- randomized run against the reference model ----
      do_reset();
      for (int c = 0; c < 600; c++) begin
         v.rst   = ($urandom_range(0, 59) == 0);
         v.rs1d  = 5'($urandom_range(0, 3));
         v.rs2d  = 5'($urandom_range(0, 3));
         v.rs1e  = 5'($urandom_range(0, 3));
         v.rs2e  = 5'($urandom_range(0, 3));
         v.rde   = 5'($urandom_range(0, 3));
         v.rdm   = 5'($urandom_range(0, 3));
         v.rdw   = 5'($urandom_range(0, 3));
         v.ld    = ($urandom_range(0, 2) == 0);
         v.rwm   = 1'($urandom_range(0, 1));
         v.rww   = 1'($urandom_range(0, 1));
         v.pcsrc = ($urandom_range(0, 4) == 0);
         v.mc    = ($urandom_range(0, 6) == 0);
         v.imem  = ($urandom_range(0, 3) != 0);
         apply("rand", v, z, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
